// File: rtl/seqdet_shift.sv
// Serial pattern detector: shifts in one bit per clock and flags when the
// newest PAT_LEN bits equal PATTERN (oldest bit compared against the MSB).
module seqdet_shift #(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10010,
  parameter bit                   OVERLAP = 1'b1
) (
  input  logic Clk,
  input  logic rst_n,
  input  logic x,
  output logic y
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  logic [PAT_LEN-1:0] sr;
  logic [PAT_LEN-1:0] sr_nxt;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_nxt;

  // Newest bit enters at the LSB, so the oldest bit lines up with PATTERN's MSB.
  generate
    if (PAT_LEN == 1) begin : g_sr_single
      always_comb sr_nxt = x;
    end else begin : g_sr_multi
      always_comb sr_nxt = {sr[PAT_LEN-2:0], x};
    end
  endgenerate

  // Saturating count of valid history bits; without overlap a match spends them.
  always_comb begin
    fill_nxt = fill;
    if (!OVERLAP && y) begin
      fill_nxt = FILL_ONE;
    end else if (fill != FILL_FULL) begin
      fill_nxt = fill + FILL_ONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      sr   <= '0;
      fill <= '0;
    end else begin
      sr   <= sr_nxt;
      fill <= fill_nxt;
    end
  end

  // Decoded from registers only; fill qualification blocks matches on stale zeros.
  assign y = (sr == PATTERN) && (fill == FILL_FULL);

endmodule

// File: tb/tb_seqdet_shift.sv
// Scoreboard bench for seqdet_shift: several configurations share one stimulus
// stream; a history-queue reference model predicts each detect flag.
module tb_seqdet_shift;

  localparam int NINST = 6;

  logic             Clk;
  logic             rst_n;
  logic             x;
  logic [NINST-1:0] y_vec;

  int total;
  int bad;
  int cyc;

  logic [NINST-1:0] exp_q[$];
  bit               hist[$];
  int               since [NINST];
  bit               prev_y[NINST];

  seqdet_shift #(.PAT_LEN(5),  .PATTERN(5'b10010), .OVERLAP(1'b1)) u_def (
    .Clk(Clk), .rst_n(rst_n), .x(x), .y(y_vec[0]));
  seqdet_shift #(.PAT_LEN(5),  .PATTERN(5'b10010), .OVERLAP(1'b0)) u_novl (
    .Clk(Clk), .rst_n(rst_n), .x(x), .y(y_vec[1]));
  seqdet_shift #(.PAT_LEN(5),  .PATTERN(5'b00000), .OVERLAP(1'b1)) u_zero (
    .Clk(Clk), .rst_n(rst_n), .x(x), .y(y_vec[2]));
  seqdet_shift #(.PAT_LEN(2),  .PATTERN(2'b11),    .OVERLAP(1'b1)) u_two (
    .Clk(Clk), .rst_n(rst_n), .x(x), .y(y_vec[3]));
  seqdet_shift #(.PAT_LEN(1),  .PATTERN(1'b1),     .OVERLAP(1'b0)) u_one (
    .Clk(Clk), .rst_n(rst_n), .x(x), .y(y_vec[4]));
  seqdet_shift #(.PAT_LEN(32), .PATTERN(32'hA5C3_0F96), .OVERLAP(1'b1)) u_wide (
    .Clk(Clk), .rst_n(rst_n), .x(x), .y(y_vec[5]));

  function automatic int cfg_len(input int k);
    case (k)
      0, 1, 2: return 5;
      3:       return 2;
      4:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] cfg_pat(input int k);
    case (k)
      0, 1:    return 32'b10010;
      2:       return 32'b00000;
      3:       return 32'b11;
      4:       return 32'b1;
      default: return 32'hA5C3_0F96;
    endcase
  endfunction

  function automatic bit cfg_ovl(input int k);
    return !(k == 1 || k == 4);
  endfunction

  // True when the newest len received bits spell the pattern, oldest first.
  function automatic bit tail_matches(input int k);
    int          len;
    logic [31:0] p;
    len = cfg_len(k);
    p   = cfg_pat(k);
    if (hist.size() < len) return 1'b0;
    for (int i = 0; i < len; i++) begin
      if (hist[hist.size() - len + i] != p[len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Applies one bit for the next rising edge and queues the flag expected after it.
  task automatic drive(input bit r, input bit b);
    logic [NINST-1:0] e;
    @(negedge Clk);
    rst_n = r;
    x     = b;
    e     = '0;
    if (!r) begin
      hist.delete();
      for (int k = 0; k < NINST; k++) begin
        since[k]  = 0;
        prev_y[k] = 1'b0;
      end
    end else begin
      hist.push_back(b);
      if (hist.size() > 64) void'(hist.pop_front());
      for (int k = 0; k < NINST; k++) begin
        if (!cfg_ovl(k) && prev_y[k]) since[k] = 1;
        else since[k] = since[k] + 1;
        e[k]      = (since[k] >= cfg_len(k)) && tail_matches(k);
        prev_y[k] = e[k];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Monitor: one flag vector per edge, compared against the scoreboard head.
  initial begin
    logic [NINST-1:0] e;
    cyc = 0;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NINST; k++) begin
          total++;
          if (y_vec[k] !== e[k]) begin
            bad++;
            $display("FAIL y_inst%0d cycle %0d: got %b expected %b", k, cyc, y_vec[k], e[k]);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] word;
    int          wait_cnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    x     = 1'b0;

    do_reset(10);

    word = 32'h000C_D124;
    for (int p = 0; p < 3; p++) send_bits(word, 24);

    do_reset(1);
    send_bits(32'b10011, 5);
    send_bits(32'b10110, 5);

    do_reset(1);
    send_bits(32'b10010010, 8);

    do_reset(1);
    send_bits(32'b000000, 6);

    do_reset(1);
    send_bits(32'b1001, 4);
    do_reset(1);
    send_bits(32'b0, 1);
    send_bits(32'b10010, 5);

    do_reset(1);
    send_bits(32'b111011, 6);

    do_reset(1);
    send_bits(32'hA5C3_0F96, 32);
    send_bits(32'h0000_0F96, 12);

    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) drive(1'b0, 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 3) == 0) drive(1'b1, 1'($urandom_range(0, 1)));
      else drive(1'b1, 1'(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 1)));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge Clk);
      wait_cnt++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seqdet_shift.md
# seqdet_shift

Serial bit-pattern detector built on a shift register. It samples one input bit per clock and asserts a one-cycle flag whenever the most recent PAT_LEN bits equal PATTERN. The first-received bit is compared against the MSB of PATTERN. It sits on a serial data line as a lightweight framing/marker detector; the default configuration detects 10010 with overlap.

## Interface
- PAT_LEN, 5: pattern length in bits; legal range 1–32.
- PATTERN, 5'b10010: pattern to detect, PAT_LEN bits wide; MSB is the oldest bit.
- OVERLAP, 1: 1 lets a match's trailing bits start the next match; 0 requires PAT_LEN fresh bits after each match.
- Clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- x  input  1  serial data bit, sampled on every rising edge of Clk.
- y  output  1  detect flag; high for one cycle per match.

## Operation
- Shift register sr[PAT_LEN-1:0]: on each rising edge with rst_n=1, sr <= {sr[PAT_LEN-2:0], x}.
- Fill counter fill, 0..PAT_LEN, saturating: counts bits accepted since reset (or since the last match when OVERLAP=0).
- Match condition: (sr == PATTERN) && (fill == PAT_LEN). The fill qualification ensures all-zero or partial register contents never cause a false match, including for PATTERN=0.
- y equals the match condition. It is decoded from registers only, with no combinational path from x to y.
- OVERLAP=1: fill stays saturated after a match, so consecutive overlapping matches are all flagged.
- OVERLAP=0: on the edge following a cycle with y=1, fill restarts at 1 (counting the bit taken on that edge). The next match therefore needs PAT_LEN new bits.
- No enable input: every clock edge with rst_n=1 consumes one bit.

## Timing
- Reset: on a rising edge with rst_n=0, sr <= 0 and fill <= 0. y is 0 from that edge onward.
- Reset applied mid-stream discards the partial history; detection restarts from scratch.
- Latency: y rises in the cycle immediately after the edge that samples the final pattern bit. It stays high for exactly one cycle unless the next edge completes another match.
- First possible assertion: after the PAT_LEN-th edge following reset release.
- Overlapping default example: input 1,0,0,1,0,0,1,0 produces y high after bit 5 and after bit 8.
- Back-to-back matches (e.g., PATTERN=11, input 1,1,1) hold y high across consecutive cycles when OVERLAP=1.
- x must be stable around the rising edge. No metastability handling is included; an asynchronous x must be synchronized upstream.

## Test plan
- Reset check: hold rst_n=0 for 10 cycles while toggling x -> y=0 throughout and on the first edge after release.
- Default pattern, rotating stream: feed the 24-bit word 0x0CD124 MSB first, repeating, starting at the first edge after reset release (edge 0) -> y high only after edges 19 and 22 of each 24-bit period (two overlapping hits: bits 15–19 and 18–22). Period 24 cycles; no other assertions.
- Near misses: input 1,0,0,1,1 then 1,0,1,1,0 -> y stays 0.
- OVERLAP=0, input 1,0,0,1,0,0,1,0 -> y high only after bit 5; bits 6–8 give no hit.
- PATTERN=5'b00000 with input of five zeros directly after reset -> y high only after the 5th edge, never earlier.
- Mid-stream reset: after 1,0,0,1, pulse rst_n=0 for one edge, then send 0 -> y stays 0. A fresh 1,0,0,1,0 then gives y=1 after the 5th bit.
